// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH clock-enable generators running on a single clock.
// Each channel divides CLK_IN1 by its own runtime-programmable divisor and emits
// a one-cycle CE pulse at a programmable phase, plus a 50% TOGGLE strobe.
//
// Ports:
//   CLK_IN1    sole clock
//   RESET      asynchronous active-high reset
//   SYNC       synchronous realign: counters and toggles to 0, pending config applied
//   CFG_WE     config write strobe (accepted when idle and CFG_CH is in range)
//   CFG_CH     target channel of the write
//   CFG_DIV    new divisor (0 = channel off, 1 = CE always high)
//   CFG_PHASE  new phase, clamped to div-1
//   CFG_BUSY   a staged config is waiting for its channel to wrap
//   CE         per-channel one-cycle enable pulses
//   TOGGLE     per-channel square wave, flips with every CE
//   LOCKED     no SYNC or config apply for LOCK_CYCLES cycles
module clk_div_bank #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CH_W        = 1,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DIV_RESET   = 4,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic              CLK_IN1,
  input  logic              RESET,
  input  logic              SYNC,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [CNT_W-1:0]  CFG_DIV,
  input  logic [CNT_W-1:0]  CFG_PHASE,
  output logic              CFG_BUSY,
  output logic [NUM_CH-1:0] CE,
  output logic [NUM_CH-1:0] TOGGLE,
  output logic              LOCKED
);

  localparam int unsigned      LockW    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CH_W:0]    NumChVal = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DivRst   = CNT_W'(DIV_RESET);
  localparam logic [LockW-1:0] LockMax  = LockW'(LOCK_CYCLES);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, div_q, phase_q;
  logic [NUM_CH-1:0]            ce_q, tog_q;
  logic                         busy_q;
  logic [CH_W-1:0]              stg_ch_q;
  logic [CNT_W-1:0]             stg_div_q, stg_phase_q;
  logic [LockW-1:0]             lock_q;

  logic [NUM_CH-1:0][CNT_W-1:0] div_m1, ph_eff;
  logic [NUM_CH-1:0]            wrap, hit, apply_ch, ce_d;
  logic                         apply_any, cfg_accept;

  always_comb begin
    div_m1   = '0;
    ph_eff   = '0;
    wrap     = '0;
    hit      = '0;
    apply_ch = '0;
    ce_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      div_m1[i]   = div_q[i] - CNT_W'(1);
      ph_eff[i]   = (phase_q[i] > div_m1[i]) ? div_m1[i] : phase_q[i];
      wrap[i]     = (div_q[i] != '0) && (cnt_q[i] == div_m1[i]);
      hit[i]      = busy_q && (stg_ch_q == CH_W'(i));
      // Apply only at the period seam so the running period is never cut short;
      // idle (div 0) channels have no seam, so apply at once.
      apply_ch[i] = hit[i] && ((div_q[i] == '0) || wrap[i]);
      ce_d[i]     = (div_q[i] != '0) && (cnt_q[i] == ph_eff[i]);
    end
  end

  assign apply_any  = |apply_ch;
  assign cfg_accept = CFG_WE && !busy_q && ({1'b0, CFG_CH} < NumChVal);

  always_ff @(posedge CLK_IN1 or posedge RESET) begin
    if (RESET) begin
      cnt_q       <= '0;
      div_q       <= {NUM_CH{DivRst}};
      phase_q     <= '0;
      ce_q        <= '0;
      tog_q       <= '0;
      busy_q      <= 1'b0;
      stg_ch_q    <= '0;
      stg_div_q   <= '0;
      stg_phase_q <= '0;
      lock_q      <= '0;
    end else if (SYNC) begin
      // Realign wins over everything, including a coincident CFG_WE.
      cnt_q  <= '0;
      ce_q   <= '0;
      tog_q  <= '0;
      busy_q <= 1'b0;
      lock_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i]) begin
          div_q[i]   <= stg_div_q;
          phase_q[i] <= stg_phase_q;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // CE on the apply edge still follows the outgoing settings.
        ce_q[i] <= ce_d[i];
        if (ce_d[i]) begin
          tog_q[i] <= ~tog_q[i];
        end
        if (apply_ch[i]) begin
          cnt_q[i]   <= '0;
          div_q[i]   <= stg_div_q;
          phase_q[i] <= stg_phase_q;
        end else if (wrap[i] || (div_q[i] == '0)) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      if (apply_any) begin
        busy_q <= 1'b0;
        lock_q <= '0;
      end else begin
        if (cfg_accept) begin
          busy_q      <= 1'b1;
          stg_ch_q    <= CFG_CH;
          stg_div_q   <= CFG_DIV;
          stg_phase_q <= CFG_PHASE;
        end
        if (lock_q != LockMax) begin
          lock_q <= lock_q + LockW'(1);
        end
      end
    end
  end

  assign CE       = ce_q;
  assign TOGGLE   = tog_q;
  assign CFG_BUSY = busy_q;
  assign LOCKED   = (lock_q == LockMax);

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with NUM_CH=2, CH_W=2, DIV_RESET=4, LOCK_CYCLES=16.
// Edges are numbered from reset release; outputs are sampled 1 ns after each edge.
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_phase;
  logic       cfg_busy;
  logic [1:0] ce;
  logic [1:0] toggle;
  logic       locked;

  logic [5:0] obs;
  logic [5:0] exp;
  logic [5:0] msk;
  logic       c0, c1, t0, t1, lk, bz;
  int         errors  = 0;
  int         checks  = 0;
  int         edge_no = 0;
  int         k;

  clk_div_bank #(
    .NUM_CH     (2),
    .CH_W       (2),
    .CNT_W      (8),
    .DIV_RESET  (4),
    .LOCK_CYCLES(16)
  ) dut (
    .CLK_IN1  (clk),
    .RESET    (rst),
    .SYNC     (sync),
    .CFG_WE   (cfg_we),
    .CFG_CH   (cfg_ch),
    .CFG_DIV  (cfg_div),
    .CFG_PHASE(cfg_phase),
    .CFG_BUSY (cfg_busy),
    .CE       (ce),
    .TOGGLE   (toggle),
    .LOCKED   (locked)
  );

  always #5 clk = ~clk;

  // Bit order: {CE[1], CE[0], TOGGLE[1], TOGGLE[0], LOCKED, CFG_BUSY}
  assign obs = {ce, toggle, locked, cfg_busy};

  task automatic tick();
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", obs, 6'b000000);
    end
    rst = 1'b0;
    edge_no = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      k  = edge_no;
      c0 = (k % 4 == 1);
      t0 = (((k + 3) / 4) % 2 == 1);
      exp = {c0, c0, t0, t0, (k >= 16), 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL defaults edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    tick();
    tick();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2; cfg_phase = 8'd1;
    for (int n = 0; n < 18; n++) begin
      tick();
      k = edge_no;
      if (k == 23) cfg_we = 1'b0;
      c0 = (k % 4 == 1);
      t0 = (((k + 3) / 4) % 2 == 1);
      c1 = (k <= 24) ? (k % 4 == 1) : (k % 2 == 0);
      t1 = (k <= 25) ? 1'b0 : (((k - 26) / 2) % 2 == 0);
      lk = (k == 23) || (k >= 40);
      bz = (k == 23);
      exp = {c1, c0, t1, t0, lk, bz};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reconfig edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_disable();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_phase = 8'd0;
    for (int n = 0; n < 14; n++) begin
      tick();
      k = edge_no;
      if (k == 41) cfg_we = 1'b0;
      if (k == 48) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_phase = 8'd0;
      end
      if (k == 49) cfg_we = 1'b0;
      c0 = (k == 41) || (k >= 51);
      t0 = (k <= 50) ? 1'b1 : ((k - 51) % 2 == 1);
      c1 = (k % 2 == 0);
      t1 = (((k - 26) / 2) % 2 == 0);
      lk = (k < 44);
      bz = (k <= 43) || (k == 49);
      exp = {c1, c0, t1, t0, lk, bz};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL div0_div1 edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_phase_clamp();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4; cfg_phase = 8'd7;
    for (int n = 0; n < 12; n++) begin
      tick();
      k = edge_no;
      if (k == 55) cfg_we = 1'b0;
      c0 = 1'b1;
      t0 = ((k - 51) % 2 == 1);
      c1 = (k == 56) || (k == 60) || (k == 64);
      t1 = (k == 55) ? 1'b1 : (((k - 56) / 4) % 2 == 1);
      exp = {c1, c0, t1, t0, 1'b0, (k == 55)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL phase_clamp edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_sync();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_phase = 8'd0;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL sync_stage0 edge %0d: got busy %b want 1", edge_no, cfg_busy);
    end
    tick();
    checks++;
    if (cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL sync_apply0 edge %0d: got busy %b want 0", edge_no, cfg_busy);
    end
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4; cfg_phase = 8'd2;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL sync_stage1 edge %0d: got busy %b want 1", edge_no, cfg_busy);
    end
    sync = 1'b1;
    for (int n = 0; n < 11; n++) begin
      tick();
      k = edge_no;
      if (k == 70) sync = 1'b0;
      c0 = (k >= 71) && ((k - 71) % 3 == 0);
      t0 = (k >= 71) && (((k - 71) / 3) % 2 == 0);
      c1 = (k >= 73) && ((k - 73) % 4 == 0);
      t1 = (k >= 73) && (((k - 73) / 4) % 2 == 0);
      exp = {c1, c0, t1, t0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sync edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_ignored();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd6; cfg_phase = 8'd0;
    for (int n = 0; n < 10; n++) begin
      tick();
      k = edge_no;
      if (k == 81) begin
        cfg_ch = 2'd0; cfg_div = 8'd0;
      end
      if (k == 82) begin
        cfg_ch = 2'd3; cfg_div = 8'd0;
      end
      if (k == 83) begin
        cfg_ch = 2'd0; cfg_div = 8'd0; sync = 1'b1;
      end
      if (k == 84) begin
        cfg_we = 1'b0; sync = 1'b0;
      end
      c0 = (k == 83) || (k == 85) || (k == 88);
      c1 = (k == 81) || (k == 83) || (k == 85);
      t0 = (k >= 85) && (k <= 87);
      t1 = (k >= 85);
      exp = {c1, c0, t1, t0, 1'b0, (k == 81)};
      msk = (k >= 84) ? 6'b111111 : 6'b110011;
      checks++;
      if ((obs & msk) !== (exp & msk)) begin
        errors++;
        $display("FAIL ignored_we edge %0d: got %b want %b mask %b", k, obs, exp, msk);
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; cfg_phase = 8'd0;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_stage: got busy %b want 1", cfg_busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", obs, 6'b000000);
    end
    tick();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_hold2: got %b want %b", obs, 6'b000000);
    end
    rst = 1'b0;
    edge_no = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      k  = edge_no;
      c0 = (k % 4 == 1);
      t0 = (((k + 3) / 4) % 2 == 1);
      exp = {c0, c0, t0, t0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL after_reset edge %0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = 2'd0; cfg_div = 8'd0; cfg_phase = 8'd0;
    test_reset();
    test_reconfig();
    test_disable();
    test_phase_clamp();
    test_sync();
    test_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised clock-enable generator bank; successor to the fixed two-output clock manager wrapper.
- Runs entirely on CLK_IN1 and produces NUM_CH independent divided clock-enable pulses (CE) plus 50% square strobes (TOGGLE).
- Each channel has its own divide ratio and phase, reprogrammable at runtime without glitches.
- Provides SYNC realignment and a LOCKED status used by downstream logic (e.g. 25 MHz pixel enable from a 100 MHz clock) in place of extra BUFG clocks.

Parameters:
- NUM_CH, 2, number of output channels (1..16).
- CH_W, 1, width of CFG_CH; must be at least clog2(NUM_CH), minimum 1.
- CNT_W, 8, width of per-channel counter, divisor and phase.
- DIV_RESET, 4, divisor loaded into every channel at reset.
- LOCK_CYCLES, 16, stable cycles required before LOCKED asserts (at least 1).

Ports:
- CLK_IN1  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- SYNC  in  1  synchronous realign of all channels.
- CFG_WE  in  1  config write strobe, one cycle.
- CFG_CH  in  CH_W  channel index for the write.
- CFG_DIV  in  CNT_W  new divisor.
- CFG_PHASE  in  CNT_W  new phase.
- CFG_BUSY  out  1  a staged config is pending.
- CE  out  NUM_CH  per-channel one-cycle enable pulse.
- TOGGLE  out  NUM_CH  per-channel square wave, period 2*div.
- LOCKED  out  1  all channels stable for LOCK_CYCLES.

Behaviour:
- Reset values (asynchronous, on RESET high):
  - counters 0, div = DIV_RESET, phase 0.
  - CE 0, TOGGLE 0, LOCKED 0, CFG_BUSY 0, lock counter 0, staging register empty.
- Per-channel counter cnt[i], for div[i] of 2 or more:
  - counts 0..div[i]-1 and wraps to 0.
  - Registered CE[i] is high in the cycle after cnt[i]==phase_eff[i], where phase_eff = min(phase, div-1).
  - Exactly one CE per div cycles.
  - With phase 0, the first CE occurs after the first rising edge following RESET release.
- div[i]==1: CE[i] is constantly high from the first edge after reset or apply.
- div[i]==0: channel disabled; CE[i] is 0, TOGGLE[i] holds its value, counter holds at 0.
- TOGGLE[i] flips on the same edge that raises CE[i].
- Config write:
  - CFG_WE with CFG_BUSY==0 and CFG_CH<NUM_CH captures CH/DIV/PHASE into a single staging register.
  - CFG_BUSY goes 1 on the next cycle.
  - CFG_WE while busy, or with CFG_CH>=NUM_CH, is ignored (no state change).
- Config apply:
  - Staged values take effect on the edge where the target channel wraps (cnt==div-1); that counter restarts at 0 with the new div/phase.
  - If the target's current div is 0 or 1, apply happens on the next edge.
  - CFG_BUSY clears on the apply edge.
  - No CE pulse is shortened or duplicated across an apply.
- SYNC high at an edge:
  - all counters go to 0 and all TOGGLE go to 0.
  - CE is 0 that cycle, except channels whose phase_eff==0, which pulse on the following edge.
  - A pending config is applied on the same edge and CFG_BUSY clears.
  - SYNC takes priority over a simultaneous wrap, CFG_WE, or apply; a CFG_WE coinciding with SYNC is ignored.
- LOCKED:
  - lock counter increments each cycle, saturating at LOCK_CYCLES; LOCKED = (counter==LOCK_CYCLES).
  - Any SYNC or config apply clears the counter and LOCKED on that edge.
  - CE/TOGGLE keep running while unlocked.
- RESET asserted mid-operation aborts any pending config immediately; all state returns to reset values.
- Arithmetic is unsigned, width CNT_W; no overflow is possible since cnt < div ≤ 2^CNT_W-1.

Test Plan:
- Reset, defaults (DIV_RESET=4, phase 0) -> CE[0], CE[1] high on edges 1,5,9...; TOGGLE period 8 cycles; LOCKED rises on edge 16.
- Write ch1 div=2 phase=1 mid-period -> CFG_BUSY high until ch1 wraps; afterwards CE[1] every 2 cycles, offset 1; no 1-cycle or double pulse at the seam; LOCKED drops, then re-asserts 16 cycles later.
- Write ch0 div=0, then div=1 -> CE[0] stays low with TOGGLE frozen; then CE[0] is constant high from the next edge.
- Phase 7 with div 4 -> behaves as phase 3; SYNC with ch0 phase 0, ch1 phase 2 -> both counters 0, CE[0] the next cycle, CE[1] three cycles later, TOGGLEs cleared.
- CFG_WE while busy, and CFG_CH=3 with NUM_CH=2 -> no effect on staged values or channels; SYNC+CFG_WE in the same cycle -> write ignored.
- RESET pulse while busy and mid-count -> all outputs return to reset values asynchronously; the staged config is never applied.
